// File: rtl/uart_pkg.sv
// Shared constants and serializer state encoding for the buffered UART transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int BIT_IDX_W            = $clog2(UART_DATA_BITS);
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // The encoding is visible to software through o_sm_main, so values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4
    } sm_state_t;

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock byte FIFO with occupancy count, same-cycle push/pop and a dropped-push pulse.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Full is taken from the registered count, so a pop in the same cycle does not make room.
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push_ok  = i_push && !o_full;
    assign w_pop_ok   = i_pop && !o_empty;
    assign o_data     = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_push && o_full;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Byte FIFO feeding an 8N1 LSB-first UART serializer, with debug status outputs.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter  int FIFO_DEPTH   = 16,
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [7:0]       i_wr_data,
    output logic             o_full,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tx_serial,
    output logic             o_tx_active,
    output logic             o_tx_done,
    output logic             o_uart_clk_edge,
    output logic [2:0]       o_sm_main
);

    localparam int                  BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(UART_DATA_BITS - 1);

    sm_state_t                   r_state,       w_state_nxt;
    logic [BAUD_W-1:0]           r_baud_cnt,    w_baud_cnt_nxt;
    logic [BIT_IDX_W-1:0]        r_bit_idx,     w_bit_idx_nxt;
    logic [UART_DATA_BITS-1:0]   r_shift,       w_shift_nxt;
    logic                        r_tx_serial,   w_tx_serial_nxt;
    logic                        r_tx_done,     w_tx_done_nxt;
    logic                        w_pop;
    logic                        w_baud_last;
    logic [7:0]                  w_fifo_data;
    logic                        w_fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (i_wr_en),
        .i_data     (i_wr_data),
        .i_pop      (w_pop),
        .o_data     (w_fifo_data),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_empty    (w_fifo_empty),
        .o_overflow (o_overflow)
    );

    assign w_baud_last     = (r_baud_cnt == BAUD_LAST);
    assign o_tx_active     = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);
    assign o_uart_clk_edge = o_tx_active && w_baud_last;
    assign o_tx_serial     = r_tx_serial;
    assign o_tx_done       = r_tx_done;
    assign o_sm_main       = r_state;

    // Next-state and datapath decode; line and done are registered, so they lag the state by one cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_baud_cnt_nxt  = r_baud_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_tx_serial_nxt = 1'b1;
        w_tx_done_nxt   = 1'b0;
        w_pop           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_baud_cnt_nxt = '0;
                w_bit_idx_nxt  = '0;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_data;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_tx_serial_nxt = 1'b0;
                if (w_baud_last) begin
                    w_baud_cnt_nxt = '0;
                    w_state_nxt    = ST_DATA;
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                w_tx_serial_nxt = r_shift[r_bit_idx];
                if (w_baud_last) begin
                    w_baud_cnt_nxt = '0;
                    if (r_bit_idx == BIT_LAST) begin
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_baud_last) begin
                    w_baud_cnt_nxt = '0;
                    w_state_nxt    = ST_CLEANUP;
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            ST_CLEANUP: begin
                w_tx_done_nxt = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_baud_cnt_nxt = '0;
                w_bit_idx_nxt  = '0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    // Serializer state register; reset drops any partial frame and returns the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_tx_serial <= 1'b1;
            r_tx_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_baud_cnt  <= w_baud_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_tx_serial <= w_tx_serial_nxt;
            r_tx_done   <= w_tx_done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench: a transaction-level model predicts FIFO occupancy and frame launch times,
// a negedge monitor checks the TX line and status outputs against the predicted frames.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int FRAME = 10 * CPB + 2;

    typedef struct {
        logic [7:0] b;
        int         e;
    } frame_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             full, overflow, tx_serial, tx_active, tx_done, uart_edge;
    logic [CNT_W-1:0] count;
    logic [2:0]       sm_main;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int epoch    = 0;
    int t_free   = 0;
    logic         m_ovf = 1'b0;
    logic [7:0]   mq[$];
    frame_t       fq[$];

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_wr_en         (wr_en),
        .i_wr_data       (wr_data),
        .o_full          (full),
        .o_overflow      (overflow),
        .o_count         (count),
        .o_tx_serial     (tx_serial),
        .o_tx_active     (tx_active),
        .o_tx_done       (tx_done),
        .o_uart_clk_edge (uart_edge),
        .o_sm_main       (sm_main)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    // Expected line level at offset o from the first low cycle of a frame.
    function automatic int exp_line(input logic [7:0] b, input int o);
        int s;
        s = o / CPB;
        if (s == 0) return 0;
        if (s <= 8) return int'(b[s-1]);
        return 1;
    endfunction

    // Expected state d cycles after the pop edge: START, DATA, STOP, CLEANUP, then IDLE.
    function automatic int exp_sm(input int d);
        if (d < CPB) return 1;
        if (d < 9 * CPB) return 2;
        if (d < 10 * CPB) return 3;
        if (d == 10 * CPB) return 4;
        return 0;
    endfunction

    // Reference model: a byte queue plus the rule that the serializer may pop once per frame period.
    initial forever begin
        int     pre;
        frame_t f;
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
            fq.delete();
            t_free = cyc + 1;
            m_ovf  = 1'b0;
            epoch++;
        end else begin
            pre = mq.size();
            if (cyc >= t_free && pre > 0) begin
                f.b = mq.pop_front();
                f.e = cyc;
                fq.push_back(f);
                t_free = cyc + FRAME;
            end
            m_ovf = wr_en && (pre == DEPTH);
            if (wr_en && pre < DEPTH) mq.push_back(wr_data);
        end
    end

    // Monitor: compares outputs with the model every cycle and follows each frame on the line.
    initial begin
        int         last_epoch = 0;
        bit         in_frame = 0;
        int         t0 = 0;
        int         pop_e = 0;
        int         n_edges = 0;
        int         o;
        logic [7:0] cur_b = 8'h00;
        frame_t     f;
        forever begin
            @(negedge clk);
            if (epoch != last_epoch) begin
                last_epoch = epoch;
                in_frame   = 0;
            end
            check("count", int'(count), mq.size());
            check("full", int'(full), int'(mq.size() == DEPTH));
            check("overflow", int'(overflow), int'(m_ovf));
            if (!in_frame && tx_serial == 1'b0) begin
                check("start_has_queued_frame", int'(fq.size() > 0), 1);
                if (fq.size() > 0) begin
                    f = fq.pop_front();
                    check("start_cycle", cyc, f.e + 1);
                    cur_b    = f.b;
                    pop_e    = f.e;
                    t0       = cyc;
                    n_edges  = 0;
                    in_frame = 1;
                end
            end
            if (in_frame) begin
                o = cyc - t0;
                if (uart_edge) n_edges++;
                check("sm_main", int'(sm_main), exp_sm(cyc - pop_e));
                if (o < 10 * CPB) begin
                    check("tx_line", int'(tx_serial), exp_line(cur_b, o));
                    check("tx_active", int'(tx_active), int'((cyc - pop_e) < 10 * CPB));
                    check("tx_done_early", int'(tx_done), 0);
                end else begin
                    check("tx_done", int'(tx_done), 1);
                    check("tx_line_cleanup", int'(tx_serial), 1);
                    check("edges_per_frame", n_edges, 10);
                    in_frame = 0;
                end
            end else begin
                if (tx_done) check("unexpected_done", int'(tx_done), 0);
                if (uart_edge) check("unexpected_baud_edge", int'(uart_edge), 0);
            end
        end
    end

    task automatic push1(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        wr_en = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: line high, state IDLE, empty FIFO.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_tx", int'(tx_serial), 1);
            check("idle_sm", int'(sm_main), 0);
            check("idle_count", int'(count), 0);
        end

        // Single frame.
        push1(8'h55);
        idle(60);

        // Back-to-back frames.
        push1(8'hA3);
        push1(8'h0F);
        idle(2 * FRAME + 20);

        // Fill to full and drop one push.
        for (int i = 1; i <= 6; i++) push1(8'(i));
        idle(5 * FRAME + 20);

        // Reset in the middle of a data phase with bytes queued.
        push1(8'hFF);
        push1(8'h11);
        push1(8'h22);
        idle(16);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_tx", int'(tx_serial), 1);
        check("rst_count", int'(count), 0);
        check("rst_sm", int'(sm_main), 0);
        check("rst_active", int'(tx_active), 0);
        rst = 1'b0;
        idle(3 * FRAME);

        // Random traffic: sparse, then dense enough to overflow.
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            if (i < 800) wr_en = ($urandom_range(0, 19) == 0);
            else         wr_en = ($urandom_range(0, 2) == 0);
            wr_data = 8'($urandom);
        end
        idle((DEPTH + 2) * FRAME + 20);

        check("frames_pending_at_end", fq.size(), 0);
        check("end_count", int'(count), 0);
        check("end_sm", int'(sm_main), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
